// File: rtl/digit_scanner.sv
// Multiplexed display digit scanner.
// Double-buffered value, leading-zero blanking and dead time per digit slot.
module digit_scanner #(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 1000,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic                  ready,
    input  logic                  lzb,
    output logic [3:0]            input_code,
    output logic [DIGITS-1:0]     digit_enable,
    output logic                  frame_start
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam int VW = 4 * DIGITS;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [VW-1:0] disp;
    logic [VW-1:0] shadow;
    logic          pending;

    logic              tick;
    logic              wrap;
    logic              dead;
    logic              blank;
    logic [DIGITS-1:0] hi_zero;

    assign tick = (cnt == CW'(PRESCALE - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));
    assign dead = ({1'b0, cnt} < (CW + 1)'(DEAD_CYCLES));

    // hi_zero[i]: nibbles i..DIGITS-1 of the display register are all zero
    always_comb begin
        hi_zero = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hi_zero[i] = ((disp >> (4 * i)) == '0);
        end
    end

    assign blank = lzb && (idx != '0) && hi_zero[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            disp         <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            ready        <= 1'b1;
            input_code   <= '0;
            digit_enable <= '0;
            frame_start  <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            frame_start <= wrap;

            input_code <= disp[4*idx +: 4];
            if (dead || blank) begin
                digit_enable <= '0;
            end else begin
                digit_enable <= DIGITS'(1) << idx;
            end

            // swap only at frame boundaries so a frame never mixes values
            if (wrap && pending) begin
                disp    <= shadow;
                pending <= 1'b0;
                ready   <= 1'b1;
            end
            if (load && ready) begin
                shadow  <= value;
                pending <= 1'b1;
                ready   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Randomized self-checking bench for digit_scanner.
// Reference model works from elapsed cycle counts and frame rules.
module tb_digit_scanner;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int DC = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [15:0]   value;
    logic          ready;
    logic          lzb;
    logic [3:0]    input_code;
    logic [D-1:0]  digit_enable;
    logic          frame_start;

    int n_vec = 0;
    int n_err = 0;

    int          edges;
    logic [15:0] m_disp;
    logic [15:0] m_shadow;
    bit          m_pend;

    digit_scanner #(
        .DIGITS(D),
        .PRESCALE(P),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .value(value),
        .ready(ready),
        .lzb(lzb),
        .input_code(input_code),
        .digit_enable(digit_enable),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        edges    = 0;
        m_disp   = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
    endtask

    task automatic step();
        int          cnt;
        int          idx;
        bit          wrap;
        bit          acc;
        bit          blank;
        logic [3:0]  e_code;
        logic [3:0]  e_en;
        cnt    = edges % P;
        idx    = (edges / P) % D;
        wrap   = (edges % (P * D)) == (P * D - 1);
        acc    = load && !m_pend;
        e_code = 4'((m_disp >> (4 * idx)) & 16'hF);
        blank  = lzb && idx > 0 && ((m_disp >> (4 * idx)) == 0);
        e_en   = (cnt < DC || blank) ? 4'd0 : 4'(1 << idx);
        if (wrap && m_pend) begin
            m_disp = m_shadow;
            m_pend = 1'b0;
        end
        if (acc) begin
            m_shadow = value;
            m_pend   = 1'b1;
        end
        edges++;
        @(posedge clk);
        #1;
        check("input_code", 32'(input_code), 32'(e_code));
        check("digit_enable", 32'(digit_enable), 32'(e_en));
        check("frame_start", 32'(frame_start), 32'(wrap));
        check("ready", 32'(ready), 32'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        step();
        load  = 1'b0;
    endtask

    task automatic hit_reset();
        rst_n = 1'b0;
        #1;
        check("rst_code", 32'(input_code), 32'd0);
        check("rst_en", 32'(digit_enable), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        lzb   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_code", 32'(input_code), 32'd0);
        check("rst_en", 32'(digit_enable), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        rst_n = 1'b1;
        run(36);

        offer(16'h1A3F);
        run(3);
        offer(16'h5555);
        run(40);

        lzb = 1'b1;
        offer(16'h0070);
        run(40);
        lzb = 1'b0;
        run(20);
        lzb = 1'b1;
        offer(16'h0000);
        run(40);

        lzb = 1'b0;
        offer(16'hBEEF);
        run(2);
        hit_reset();
        run(36);

        for (int i = 0; i < 2500; i++) begin
            mask = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1, 0) == 1) mask[4*k +: 4] = 4'hF;
            end
            value = 16'($urandom) & mask;
            load  = ($urandom_range(7, 0) == 0);
            if ($urandom_range(15, 0) == 0) lzb = ~lzb;
            if ($urandom_range(599, 0) == 0) begin
                load = 1'b0;
                hit_reset();
            end
            step();
        end
        load = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed display digits (2..8).
REQ-002 Parameter PRESCALE, default 1000: clock cycles per digit slot (>= 4).
REQ-003 Parameter DEAD_CYCLES, default 2: blanking cycles at the start of each slot (< PRESCALE).
REQ-004 Port clk, input, 1: single system clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port load, input, 1: offer of a new display value, accepted only when ready=1.
REQ-007 Port value, input, 4*DIGITS: new display value; nibble i maps to digit i, and digit 0 is least significant.
REQ-008 Port ready, output, 1: high when the block can accept a load.
REQ-009 Port lzb, input, 1: leading-zero blanking enable, sampled every cycle.
REQ-010 Port input_code, output, 4: nibble of the active digit, driven to the display decoder's input_code.
REQ-011 Port digit_enable, output, DIGITS: one-hot active-high digit select, or all zero.
REQ-012 Port frame_start, output, 1: one-cycle pulse when scanning restarts at digit 0.

Function
REQ-013 Prescaler: counts 0..PRESCALE-1, then wraps to 0; tick is asserted when count = PRESCALE-1.
REQ-014 Digit index: advances by one on each tick, wrapping from DIGITS-1 to 0; it does not change otherwise.
REQ-015 Frame wrap: a tick with index = DIGITS-1 is a frame wrap.
REQ-016 frame_start: asserted in the cycle after a frame wrap, for exactly one cycle.
REQ-017 Registered outputs: input_code and digit_enable are registered and reflect index, prescaler count and display register with one cycle latency.
REQ-018 input_code: equals nibble[index] of the display register, regardless of blanking.
REQ-019 Dead time: digit_enable is all zero while the prescaler count < DEAD_CYCLES.
REQ-020 Active time: at other times digit_enable has only bit[index] set, unless that digit is blanked.
REQ-021 Blanking (lzb=1): digit i>0 is blanked when nibbles i..DIGITS-1 of the display register are all zero.
REQ-022 Digit 0: never blanked.
REQ-023 Blanking (lzb=0): no digit is blanked.
REQ-024 Handshake, accept: load=1 with ready=1 captures value into the shadow register, sets pending, and drives ready=0 from the next cycle.
REQ-025 Handshake, ignored load: load=1 with ready=0 is ignored, and the shadow register is unchanged.
REQ-026 Tear-free update: the display register copies the shadow register only on a frame wrap with pending=1; pending clears in the same edge, and ready returns high on the next cycle.
REQ-027 Ready relationship: ready = NOT pending, and ready is registered.
REQ-028 Load at frame wrap: a load accepted in the same cycle as a frame wrap (pending=0) is applied only at the following frame wrap.
REQ-029 Sizing: all counters are sized from the parameters using clog2, with no overflow at the maximum count.

Reset
REQ-030 Reset entry: rst_n=0 forces, asynchronously:
- prescaler = 0
- index = 0
- display register = 0
- shadow register = 0
- pending = 0
- ready = 1
- input_code = 0
- digit_enable = 0
- frame_start = 0
REQ-031 Reset mid-operation: a pending value is discarded and is never displayed.
REQ-032 Reset release: first tick occurs PRESCALE cycles after the first rising edge with rst_n=1.

Verification
Bench parameters: DIGITS=4, PRESCALE=4, DEAD_CYCLES=1.
REQ-033 Reset scan: hold rst_n=0, then release with lzb=0 -> ready=1, input_code=0 throughout, and digit_enable cycles 0000,0001×3,0000,0010×3,... through 1000.
REQ-034 Load and apply: load=1, value=16'h1A3F for one cycle -> ready=0 next cycle; old digits are shown until the frame wrap; the next frame shows input_code F,3,A,1 on enables 0001,0010,0100,1000; ready=1 one cycle after the wrap.
REQ-035 Load while busy: load=1, value=16'h5555 while ready=0 -> ignored; the display shows the earlier accepted value, never 5555.
REQ-036 Leading-zero blanking: apply value=16'h0070 with lzb=1 -> enables 0001 and 0010 are pulsed, digits 2 and 3 stay dark, and input_code still scans 0,7,0,0; with lzb=0 all four digits are enabled.
REQ-037 All-zero value: apply value=0 with lzb=1 -> only digit 0 is enabled, with input_code=0.
REQ-038 Reset while pending: assert rst_n=0 while pending=1 -> all outputs return to reset values immediately; after release the display shows 0000 and ready=1.
